bcd_stopwatch: RTL and testbench
================================

Name: bcd_stopwatch

Overview:
- Parametrised decimal run-time counter for the seven-segment display path.
- A single clock domain generates an internal tick enable; no derived clocks.
- Counts in true per-digit BCD, DIGITS wide, up or down, with start/stop/clear/load control and a wrap indication.
- Output feeds the existing seven-segment digit decoders directly, one nibble per digit.

Parameters:
- DIGITS, 6, number of BCD digits; legal range 1..8.
- TICK_DIV, 500000, clk cycles per count step (10 ms at 50 MHz); legal range 2..2^DIV_W.
- DIV_W, 20, prescaler width; must satisfy 2^DIV_W >= TICK_DIV.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; the decided reset definition is given under Behaviour.
- start  input  1  single-cycle pulse: STOPPED -> RUNNING.
- stop  input  1  single-cycle pulse: RUNNING -> STOPPED.
- clear  input  1  single-cycle pulse: count and prescaler to 0.
- dir  input  1  0 = count up, 1 = count down.
- load  input  1  single-cycle pulse: count <= load_val.
- load_val  input  4*DIGITS  BCD preset; digit 0 is in bits [3:0].
- lap  input  1  lap capture pulse; used only with LAP_HOLD_EN.
- bcd_out  output  4*DIGITS  current count (or held lap value), BCD.
- running  output  1  high while in RUNNING.
- tick  output  1  one-cycle pulse on each count step.
- wrap  output  1  one-cycle pulse when the count wraps.
- lap_active  output  1  high while the display is held; tied 0 without LAP_HOLD_EN.

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock.
- Values during rst_n low: state STOPPED, prescaler 0, count 0, bcd_out 0, running 0, tick 0, wrap 0, lap_active 0.
- States:
  - STOPPED: start -> RUNNING.
  - RUNNING: stop -> STOPPED.
  - start in RUNNING and stop in STOPPED are ignored.
- Control priority when pulses coincide in one cycle: clear > load > stop > start.
- clear: count <= 0 and prescaler <= 0; state unchanged (a running counter keeps running from 0).
- load: count <= load_val and prescaler <= 0; state unchanged. Any load_val digit > 9 is stored as 9.
- Prescaler:
  - Increments only in RUNNING.
  - Holds in STOPPED, so a resume keeps the fractional interval.
  - At TICK_DIV-1 it returns to 0 and a step occurs.
- Step, on that same clock edge:
  - count is updated and tick is registered high.
  - tick and the new bcd_out are therefore visible in the same cycle.
  - There is no step in a cycle where clear, load or stop is asserted; that cycle's prescaler terminal count is discarded.
- Up step (dir = 0):
  - Digit 0 increments.
  - A digit at 9 goes to 0 and carries into the next digit.
  - All digits 9 -> all digits 0, with wrap = 1 in the same cycle as tick.
- Down step (dir = 1):
  - Digit 0 decrements.
  - A digit at 0 goes to 9 and borrows from the next digit.
  - All digits 0 -> all digits 9, with wrap = 1.
- dir is sampled only at step edges; a change mid-interval affects the next step.
- tick and wrap are never high for more than one consecutive cycle (TICK_DIV >= 2).
- running mirrors the state register.
- Asserting rst_n mid-count returns everything to the reset values immediately, without waiting for a clk edge.

Optional Feature:
- Macro: BCD_STOPWATCH_LAP_HOLD_EN.
- Defined:
  - A lap pulse copies the current count (the value the edge produces) into a hold register and sets lap_active.
  - While lap_active = 1, bcd_out shows the hold register and the internal count keeps running.
  - A second lap pulse clears lap_active; bcd_out then shows the live count from the next cycle.
  - clear or load also clears lap_active.
- Not defined:
  - lap is ignored and lap_active is constant 0.
  - bcd_out is always the live count; no hold register is synthesised.

Test Plan (DIGITS = 3, TICK_DIV = 4):
1. Release reset, pulse start, run 40 cycles -> tick every 4th cycle; bcd_out steps 000, 001 ... 010; wrap stays 0; running = 1.
2. load 12'h998, dir = 0, start -> bcd_out 999 then 000, with wrap = 1 and tick = 1 in the same single cycle; the next step gives 001.
3. load 12'h001, dir = 1, start -> bcd_out 000 then 999 with wrap = 1; then 998.
4. Pulse stop 2 cycles after a step; wait 20 cycles; pulse start -> bcd_out frozen while stopped, and the next tick arrives 2 cycles after start (prescaler held).
5. Same-cycle clear + stop + start while running at 345 -> bcd_out 000 and running = 1. Next, load 12'hAB3 -> bcd_out 993. Then assert rst_n mid-interval -> all outputs 0 immediately.
6. With BCD_STOPWATCH_LAP_HOLD_EN: lap at count 005 -> bcd_out holds 005 for 3 steps, lap_active = 1; second lap -> bcd_out 008. Without the macro: lap changes nothing.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: decimal run-time counter for the seven-segment display path.
// A prescaler divides clk down to one count step every TICK_DIV cycles; the
// count is kept in true per-digit BCD so each nibble can feed a digit decoder.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, stop      single-cycle pulses moving STOPPED <-> RUNNING
//   clear            count and prescaler to 0, state unchanged
//   load, load_val   preset the count (digits above 9 are saturated to 9)
//   dir              0 = count up, 1 = count down (sampled on step edges)
//   lap              lap hold toggle (only with BCD_STOPWATCH_LAP_HOLD_EN)
//   bcd_out          displayed count, digit 0 in bits [3:0]
//   running          high while RUNNING
//   tick, wrap       one-cycle pulses on each step / on a wrap-around step
//   lap_active       high while the display shows the held lap value
//
// Optional feature macro: BCD_STOPWATCH_LAP_HOLD_EN enables the lap hold
// register; without it lap is ignored and lap_active is tied low.

module bcd_stopwatch #(
  parameter int DIGITS   = 6,
  parameter int TICK_DIV = 500000,
  parameter int DIV_W    = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  running,
  output logic                  tick,
  output logic                  wrap,
  output logic                  lap_active
);

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

  state_t              state;
  logic [DIV_W-1:0]    prescaler;
  logic [4*DIGITS-1:0] count;
  logic [4*DIGITS-1:0] step_val;
  logic [4*DIGITS-1:0] load_sat;
  logic                step_wrap;
  logic                carry;
  logic [3:0]          cur_digit;
  logic [3:0]          nxt_digit;
  logic                presc_term;
  logic                do_step;

  assign presc_term = (prescaler == PRESC_LAST);

  // clear, load and stop all pre-empt a step; the terminal count of that
  // cycle is simply lost.
  assign do_step = (state == RUNNING) && presc_term && !clear && !load && !stop;

  // Ripple the +1/-1 through the digits. carry doubles as borrow when
  // counting down; if it survives past the top digit the count wrapped.
  always_comb begin
    step_val  = '0;
    load_sat  = '0;
    carry     = 1'b1;
    cur_digit = '0;
    nxt_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      cur_digit = count[4*i +: 4];
      if (!carry) begin
        nxt_digit = cur_digit;
      end else if (!dir) begin
        if (cur_digit >= 4'd9) begin
          nxt_digit = 4'd0;
        end else begin
          nxt_digit = cur_digit + 4'd1;
          carry     = 1'b0;
        end
      end else begin
        if (cur_digit == 4'd0) begin
          nxt_digit = 4'd9;
        end else begin
          nxt_digit = cur_digit - 4'd1;
          carry     = 1'b0;
        end
      end
      step_val[4*i +: 4] = nxt_digit;
      load_sat[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
    step_wrap = carry;
  end

  // Control FSM, prescaler and count. The prescaler only advances while
  // RUNNING, so a stop/start pair resumes mid-interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STOPPED;
      prescaler <= '0;
      count     <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (clear) begin
        count     <= '0;
        prescaler <= '0;
      end else if (load) begin
        count     <= load_sat;
        prescaler <= '0;
      end else if (state == RUNNING) begin
        prescaler <= presc_term ? '0 : prescaler + DIV_W'(1);
        if (stop) begin
          state <= STOPPED;
        end
        if (do_step) begin
          count <= step_val;
          tick  <= 1'b1;
          wrap  <= step_wrap;
        end
      end else if (start) begin
        state <= RUNNING;
      end
    end
  end

  assign running = (state == RUNNING);

`ifdef BCD_STOPWATCH_LAP_HOLD_EN
  logic [4*DIGITS-1:0] hold;

  // The hold register captures the value this edge produces, so a lap on a
  // step edge freezes the freshly stepped count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold       <= '0;
      lap_active <= 1'b0;
    end else if (clear || load) begin
      lap_active <= 1'b0;
    end else if (lap) begin
      if (lap_active) begin
        lap_active <= 1'b0;
      end else begin
        lap_active <= 1'b1;
        hold       <= do_step ? step_val : count;
      end
    end
  end

  assign bcd_out = lap_active ? hold : count;
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign bcd_out    = count;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: self-checking bench for bcd_stopwatch (DIGITS=3, TICK_DIV=4).
// A decimal reference model is advanced on every clock edge; its expected
// outputs are queued and compared against the design one step after the edge.
// Directed checks with literal values pin down the key scenarios.

module tb_bcd_stopwatch;

  localparam int DIGITS   = 3;
  localparam int TICK_DIV = 4;
  localparam int DIV_W    = 3;
  localparam int MAXV     = 999;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic                clear = 1'b0;
  logic                dir = 1'b0;
  logic                load = 1'b0;
  logic                lap = 1'b0;
  logic [4*DIGITS-1:0] load_val = '0;
  logic [4*DIGITS-1:0] bcd_out;
  logic                running;
  logic                tick;
  logic                wrap;
  logic                lap_active;

  bcd_stopwatch #(
    .DIGITS  (DIGITS),
    .TICK_DIV(TICK_DIV),
    .DIV_W   (DIV_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .dir       (dir),
    .load      (load),
    .load_val  (load_val),
    .lap       (lap),
    .bcd_out   (bcd_out),
    .running   (running),
    .tick      (tick),
    .wrap      (wrap),
    .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*DIGITS-1:0] bcd;
    logic                run;
    logic                tck;
    logic                wrp;
    logic                lapa;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  // reference model state, decimal integers rather than BCD
  bit m_run;
  int m_presc;
  int m_count;
  int m_hold;
  bit m_lap;
  bit m_tick;
  bit m_wrap;

  function automatic logic [4*DIGITS-1:0] to_bcd(int v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int sat_value(logic [4*DIGITS-1:0] lv);
    int v;
    int d;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  task automatic resetModel();
    m_run   = 1'b0;
    m_presc = 0;
    m_count = 0;
    m_hold  = 0;
    m_lap   = 1'b0;
    m_tick  = 1'b0;
    m_wrap  = 1'b0;
  endtask

  task automatic checkValue(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("[TB] FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cycle, obs, expv);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    bit term;
    exp_t e;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (clear) begin
      m_count = 0;
      m_presc = 0;
      m_lap   = 1'b0;
    end else if (load) begin
      m_count = sat_value(load_val);
      m_presc = 0;
      m_lap   = 1'b0;
    end else begin
      if (m_run) begin
        term    = (m_presc == TICK_DIV - 1);
        m_presc = term ? 0 : m_presc + 1;
        if (stop) begin
          m_run = 1'b0;
        end else if (term) begin
          m_tick = 1'b1;
          if (!dir) begin
            m_wrap  = (m_count == MAXV);
            m_count = (m_count + 1) % (MAXV + 1);
          end else begin
            m_wrap  = (m_count == 0);
            m_count = m_wrap ? MAXV : m_count - 1;
          end
        end
      end else if (start) begin
        m_run = 1'b1;
      end
`ifdef BCD_STOPWATCH_LAP_HOLD_EN
      if (lap) begin
        if (m_lap) begin
          m_lap = 1'b0;
        end else begin
          m_lap  = 1'b1;
          m_hold = m_count;
        end
      end
`endif
    end
    e.bcd  = to_bcd(m_lap ? m_hold : m_count);
    e.run  = m_run;
    e.tck  = m_tick;
    e.wrp  = m_wrap;
    e.lapa = m_lap;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (exp_q.size() != 0)
    else begin
      failures++;
      $error("[TB] FAIL scoreboard_empty @cycle %0d: observed=0 expected=1", cycle);
    end
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    checkValue("sb_bcd_out", 32'(bcd_out), 32'(e.bcd));
    checkValue("sb_running", 32'(running), 32'(e.run));
    checkValue("sb_tick", 32'(tick), 32'(e.tck));
    checkValue("sb_wrap", 32'(wrap), 32'(e.wrp));
    checkValue("sb_lap_active", 32'(lap_active), 32'(e.lapa));
  endtask

  task automatic applyStimulus(bit s, bit p, bit c, bit l, bit lp, logic [4*DIGITS-1:0] lv);
    start    = s;
    stop     = p;
    clear    = c;
    load     = l;
    lap      = lp;
    load_val = lv;
    @(posedge clk);
    modelStep();
    cycle++;
    #1;
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    load  = 1'b0;
    lap   = 1'b0;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Run until the design reports n ticks, with a cycle budget.
  task automatic runSteps(int n);
    int seen;
    seen = 0;
    for (int k = 0; k < 16 * n && seen < n; k++) begin
      idle();
      if (tick === 1'b1) seen++;
    end
    checkValue("run_steps_ticks", 32'(seen), 32'(n));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ticks_seen;
    resetModel();

    // reset values while rst_n is low
    #2;
    checkValue("reset_bcd_out", 32'(bcd_out), 32'h0);
    checkValue("reset_running", 32'(running), 32'h0);
    checkValue("reset_tick", 32'(tick), 32'h0);
    checkValue("reset_wrap", 32'(wrap), 32'h0);
    checkValue("reset_lap_active", 32'(lap_active), 32'h0);
    #10 rst_n = 1'b1;

    // 1: free run from zero for 40 cycles
    $display("[TB] step 1: free run");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    ticks_seen = 0;
    for (int k = 0; k < 40; k++) begin
      idle();
      if (tick === 1'b1) ticks_seen++;
    end
    checkValue("run40_ticks", 32'(ticks_seen), 32'd10);
    checkValue("run40_bcd_out", 32'(bcd_out), 32'h010);
    checkValue("run40_running", 32'(running), 32'h1);

    // 2: up wrap 998 -> 999 -> 000 -> 001
    $display("[TB] step 2: up wrap");
    dir = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h998);
    runSteps(1);
    checkValue("up_999", 32'(bcd_out), 32'h999);
    runSteps(1);
    checkValue("up_wrap_bcd", 32'(bcd_out), 32'h000);
    checkValue("up_wrap_wrap", 32'(wrap), 32'h1);
    checkValue("up_wrap_tick", 32'(tick), 32'h1);
    idle();
    checkValue("up_wrap_single", 32'(wrap), 32'h0);
    runSteps(1);
    checkValue("up_001", 32'(bcd_out), 32'h001);

    // 3: down wrap 001 -> 000 -> 999 -> 998
    $display("[TB] step 3: down wrap");
    dir = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h001);
    runSteps(1);
    checkValue("dn_000", 32'(bcd_out), 32'h000);
    checkValue("dn_000_wrap", 32'(wrap), 32'h0);
    runSteps(1);
    checkValue("dn_wrap_bcd", 32'(bcd_out), 32'h999);
    checkValue("dn_wrap_wrap", 32'(wrap), 32'h1);
    runSteps(1);
    checkValue("dn_998", 32'(bcd_out), 32'h998);

    // 4: stop two cycles after a step, resume keeps the fractional interval
    $display("[TB] step 4: stop/resume");
    runSteps(1);
    idle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    repeat (20) idle();
    checkValue("stopped_bcd", 32'(bcd_out), 32'h997);
    checkValue("stopped_running", 32'(running), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle();
    checkValue("resume_no_tick_yet", 32'(tick), 32'h0);
    idle();
    checkValue("resume_tick", 32'(tick), 32'h1);
    checkValue("resume_bcd", 32'(bcd_out), 32'h996);

    // 5: priority, saturating load, asynchronous reset
    $display("[TB] step 5: priority and reset");
    dir = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h345);
    idle();
    idle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    checkValue("prio_clear_bcd", 32'(bcd_out), 32'h000);
    checkValue("prio_clear_running", 32'(running), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'hAB3);
    checkValue("load_sat_bcd", 32'(bcd_out), 32'h993);
    idle();
    #2 rst_n = 1'b0;
    #1;
    resetModel();
    checkValue("async_rst_bcd", 32'(bcd_out), 32'h0);
    checkValue("async_rst_running", 32'(running), 32'h0);
    checkValue("async_rst_tick", 32'(tick), 32'h0);
    checkValue("async_rst_lap", 32'(lap_active), 32'h0);
    #2 rst_n = 1'b1;

    // 6: lap hold
    $display("[TB] step 6: lap");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    runSteps(5);
    checkValue("lap_pre_bcd", 32'(bcd_out), 32'h005);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    runSteps(3);
`ifdef BCD_STOPWATCH_LAP_HOLD_EN
    checkValue("lap_hold_bcd", 32'(bcd_out), 32'h005);
    checkValue("lap_hold_active", 32'(lap_active), 32'h1);
`else
    checkValue("lap_ignored_bcd", 32'(bcd_out), 32'h008);
    checkValue("lap_ignored_active", 32'(lap_active), 32'h0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    checkValue("lap_release_bcd", 32'(bcd_out), 32'h008);
    checkValue("lap_release_active", 32'(lap_active), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    checkValue("lap_clear_active", 32'(lap_active), 32'h0);
    checkValue("lap_clear_bcd", 32'(bcd_out), 32'h000);
    repeat (6) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
